dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: the core has default priority, a
// starvation counter promotes the host, and h_lock holds host ownership across bursts.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wd,
   output logic              c_gnt,
   output logic              c_stall,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wd,
   input  logic              h_lock,
   output logic              h_gnt,
   output logic              h_rvalid,
   output logic [DATA_W-1:0] h_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      CORE_PRIO,
      HOST_PRIO,
      HOST_LOCK
   } state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          host_first;

   // HOST_PRIO and HOST_LOCK share one grant rule; only their exit conditions differ.
   assign host_first = (state != CORE_PRIO);
   assign c_gnt      = host_first ? (c_req & ~h_req) : c_req;
   assign h_gnt      = host_first ? h_req : (h_req & ~c_req);
   assign c_stall    = c_req & ~c_gnt;

   // Read data is broadcast; only the per-port rvalid says whose it is.
   assign c_rdata = mem_rd;
   assign h_rdata = mem_rd;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      if (c_gnt) begin
         mem_we   = c_we;
         mem_addr = c_addr;
         mem_wd   = c_wd;
      end else if (h_gnt) begin
         mem_we   = h_we;
         mem_addr = h_addr;
         mem_wd   = h_wd;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CORE_PRIO;
         wait_cnt <= '0;
         c_rvalid <= 1'b0;
         h_rvalid <= 1'b0;
      end else begin
         c_rvalid <= c_gnt & ~c_we;
         h_rvalid <= h_gnt & ~h_we;

         if (h_req & ~h_gnt) begin
            if (wait_cnt != CW'(MAX_WAIT))
               wait_cnt <= wait_cnt + CW'(1);
         end else begin
            wait_cnt <= '0;
         end

         case (state)
            CORE_PRIO: begin
               if (h_req & ~h_gnt & (wait_cnt == CW'(MAX_WAIT - 1)))
                  state <= HOST_PRIO;
            end
            HOST_PRIO: begin
               if (h_req & h_gnt)
                  state <= h_lock ? HOST_LOCK : CORE_PRIO;
               else if (~h_req)
                  state <= CORE_PRIO;
            end
            HOST_LOCK: begin
               if (~h_lock)
                  state <= CORE_PRIO;
            end
            default: state <= CORE_PRIO;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter; a behavioural RAM plus a
// priority/scoreboard model in the bench supply every expected value.
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          c_req, c_we, c_gnt, c_stall, c_rvalid;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wd, c_rdata;
   logic          h_req, h_we, h_lock, h_gnt, h_rvalid;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_wd, h_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wd, mem_rd;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) u_dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
      .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wd(h_wd), .h_lock(h_lock),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // Synchronous RAM driven purely by the DUT's memory-side outputs.
   logic [DW-1:0] ram [256];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wd;
      mem_rd <= ram[mem_addr[7:0]];
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: who currently owns priority, how long the host has waited,
   // what the next cycle's read return should be, and the RAM contents.
   bit            m_host_prio, m_locked;
   int            m_denials;
   bit            exp_crv, exp_hrv;
   logic [DW-1:0] exp_rd;
   logic [DW-1:0] model_mem [256];
   logic          a_cg, a_hg, a_cs;

   task automatic model_reset();
      m_host_prio = 0;
      m_locked    = 0;
      m_denials   = 0;
      exp_crv     = 0;
      exp_hrv     = 0;
   endtask

   task automatic step(input logic cr, input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                       input logic hr, input logic hwe, input logic [AW-1:0] ha, input logic [DW-1:0] hwd,
                       input logic hl, output logic gc, output logic gh);
      bit host_first, eg_c, eg_h, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      @(negedge clk);
      c_req = cr; c_we = cwe; c_addr = ca; c_wd = cwd;
      h_req = hr; h_we = hwe; h_addr = ha; h_wd = hwd; h_lock = hl;
      #1;
      check("c_rvalid", c_rvalid, exp_crv);
      check("h_rvalid", h_rvalid, exp_hrv);
      if (exp_crv) check("c_rdata", c_rdata, exp_rd);
      if (exp_hrv) check("h_rdata", h_rdata, exp_rd);

      host_first = m_host_prio || m_locked;
      eg_c = cr && !(host_first && hr);
      eg_h = hr && !(!host_first && cr);
      e_we = 0; e_addr = '0; e_wd = '0;
      if (eg_c) begin e_we = cwe; e_addr = ca; e_wd = cwd; end
      if (eg_h) begin e_we = hwe; e_addr = ha; e_wd = hwd; end
      check("c_gnt", c_gnt, eg_c);
      check("h_gnt", h_gnt, eg_h);
      check("c_stall", c_stall, cr && !eg_c);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wd", mem_wd, e_wd);
      a_cg = c_gnt; a_hg = h_gnt; a_cs = c_stall;

      exp_crv = eg_c && !cwe;
      exp_hrv = eg_h && !hwe;
      exp_rd  = model_mem[e_addr[7:0]];
      if ((eg_c || eg_h) && e_we) model_mem[e_addr[7:0]] = e_wd;

      // Priority bookkeeping from the arbitration rules.
      if (m_locked) begin
         if (!hl) m_locked = 0;
      end else if (m_host_prio) begin
         if (!hr || eg_h) begin
            m_host_prio = 0;
            m_locked    = hr && hl;
         end
      end else if (hr && !eg_h && m_denials + 1 >= MW) begin
         m_host_prio = 1;
      end
      if (hr && !eg_h) m_denials = (m_denials < MW) ? m_denials + 1 : MW;
      else m_denials = 0;
      gc = eg_c;
      gh = eg_h;
   endtask

   task automatic idle(output logic gc, output logic gh);
      step(0, 0, '0, '0, 0, 0, '0, '0, 0, gc, gh);
   endtask

   initial begin
      logic gc, gh;
      int first, last, k, core_after;
      logic cp, cwe_r, hp, hwe_r, hl_r;
      logic [AW-1:0] ca_r, ha_r;
      logic [DW-1:0] cwd_r, hwd_r;

      for (int i = 0; i < 256; i++) begin
         ram[i] = $urandom;
         model_mem[i] = ram[i];
      end
      reset = 1'b1;
      c_req = 0; c_we = 0; c_addr = '0; c_wd = '0;
      h_req = 0; h_we = 0; h_addr = '0; h_wd = '0; h_lock = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_c_rvalid", c_rvalid, 0);
      check("rst_h_rvalid", h_rvalid, 0);
      check("rst_c_gnt", c_gnt, 0);
      check("rst_h_gnt", h_gnt, 0);
      check("rst_c_stall", c_stall, 0);
      reset = 1'b0;

      // Core read with no host traffic; data returns next cycle.
      step(1, 0, 32'h10, '0, 0, 0, '0, '0, 0, gc, gh);
      check("tp1_c_gnt", a_cg, 1);
      check("tp1_c_stall", a_cs, 0);
      idle(gc, gh);

      // Host write while core idle, then core reads it back.
      step(0, 0, '0, '0, 1, 1, 32'h40, 32'hDEADBEEF, 0, gc, gh);
      check("tp2_h_gnt", a_hg, 1);
      step(1, 0, 32'h40, '0, 0, 0, '0, '0, 0, gc, gh);
      step(0, 0, '0, '0, 0, 0, '0, '0, 0, gc, gh);
      check("tp2_rdata", c_rdata, 32'hDEADBEEF);

      // Starvation: core requests every cycle, host from cycle 0.
      first = -1;
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 32'(i), '0, first < 0, 1, 32'h80, 32'h1234, 0, gc, gh);
         if (first < 0 && a_hg) begin
            first = i;
            check("starve_stall", a_cs, 1);
         end else if (first >= 0 && i == first + 1) begin
            check("starve_core_back", a_cg, 1);
         end
      end
      check("starve_cycle", first, MW);
      idle(gc, gh);

      // Host locked burst of 4 writes against a constantly requesting core.
      first = -1; last = -1; k = 0; core_after = 0;
      for (int i = 0; i < 14; i++) begin
         step(1, 1, 32'hA0, 32'(i), k < 4, 1, 32'(k * 4), 32'hB000 + 32'(k), k < 3, gc, gh);
         if (a_hg) begin
            if (first < 0) first = i;
            last = i;
            k++;
         end
         if (last >= 0 && i == last + 1) core_after = a_cg;
      end
      check("burst_len", last - first, 3);
      check("burst_core_after", core_after, 1);
      check("burst_mem_c", model_mem[12], 32'hB003);

      // Enter HOST_LOCK, then host goes idle with lock held: core uses the gaps.
      k = 0;
      for (int i = 0; i < 8 && k == 0; i++) begin
         step(1, 0, 32'h20, '0, 1, 1, 32'h30, 32'h55, 1, gc, gh);
         if (a_hg) k = 1;
      end
      check("lock_won", k, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 32'h21 + 32'(i), '0, 0, 0, '0, '0, 1, gc, gh);
         check("lock_idle_core", a_cg, 1);
      end
      step(1, 0, 32'h24, '0, 1, 0, 32'h30, '0, 1, gc, gh);
      check("lock_still_host", a_hg, 1);
      step(1, 0, 32'h25, '0, 0, 0, '0, '0, 0, gc, gh);
      step(1, 0, 32'h26, '0, 1, 0, 32'h31, '0, 0, gc, gh);
      check("unlock_core_wins", a_cg, 1);
      idle(gc, gh);

      // Reset right after a granted core read drops the pending rvalid.
      step(1, 0, 32'h10, '0, 0, 0, '0, '0, 0, gc, gh);
      @(negedge clk);
      c_req = 0;
      #1;
      check("pre_rst_rvalid", c_rvalid, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_rvalid", c_rvalid, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step(1, 0, 32'h11, '0, 1, 0, 32'h12, '0, 0, gc, gh);
      check("post_rst_core", a_cg, 1);
      idle(gc, gh);

      // Random traffic; each requester holds its request until granted.
      cp = 0; hp = 0; cwe_r = 0; hwe_r = 0; hl_r = 0;
      ca_r = '0; ha_r = '0; cwd_r = '0; hwd_r = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!cp) begin
            cp = ($urandom % 3) != 0;
            cwe_r = $urandom % 2; ca_r = $urandom % 256; cwd_r = $urandom;
         end
         if (!hp) begin
            hp = ($urandom % 2) != 0;
            hwe_r = $urandom % 2; ha_r = $urandom % 256; hwd_r = $urandom;
            hl_r = ($urandom % 3) == 0;
         end
         step(cp, cwe_r, ca_r, cwd_r, hp, hwe_r, ha_r, hwd_r, hl_r, gc, gh);
         if (gc) cp = 0;
         if (gh) hp = 0;
      end
      idle(gc, gh);
      idle(gc, gh);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
